// File: rtl/mul24_pkg.sv
// Shared widths, FSM state type and result record for the sequential Q1.23 mantissa multiplier.
package mul24_pkg;

    localparam int MANT_W     = 24;
    localparam int PROD_W     = 48;
    localparam int STEP_CNT_W = 5;

    localparam logic [STEP_CNT_W-1:0] LAST_STEP = STEP_CNT_W'(MANT_W - 1);

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        NORM,
        DONE
    } state_t;

    typedef struct packed {
        logic [MANT_W-1:0] mant;
        logic              exp_inc;
    } result_t;

endpackage

// File: rtl/seq_mul24_frac_if.sv
// Operand/result handshake bundle for seq_mul24_frac; the multiplier is the slave side.
interface seq_mul24_frac_if;
    import mul24_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic [MANT_W-1:0] a;
    logic [MANT_W-1:0] b;
    logic              out_valid;
    logic              out_ready;
    logic [MANT_W-1:0] mant;
    logic              exp_inc;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, mant, exp_inc
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, mant, exp_inc
    );

endinterface

// File: rtl/mul24_norm_round.sv
// Combinational normalizer: 48-bit Q2.46 product -> Q1.23 mantissa plus exponent-increment flag.
// Define MUL24_ROUND_EN for round-to-nearest-even; otherwise the product is truncated.
module mul24_norm_round
    import mul24_pkg::*;
(
    input  logic [PROD_W-1:0] i_prod,
    output logic [MANT_W-1:0] o_mant,
    output logic              o_exp_inc
);

    logic              w_top;
    logic [MANT_W-1:0] w_mant_trunc;

    assign w_top        = i_prod[PROD_W-1];
    assign w_mant_trunc = w_top ? i_prod[47:24] : i_prod[46:23];

`ifdef MUL24_ROUND_EN
    logic          w_guard;
    logic          w_sticky;
    logic          w_round_up;
    logic [MANT_W:0] w_rounded;

    assign w_guard    = w_top ? i_prod[23] : i_prod[22];
    assign w_sticky   = w_top ? (|i_prod[22:0]) : (|i_prod[21:0]);
    assign w_round_up = w_guard & (w_sticky | w_mant_trunc[0]);
    assign w_rounded  = {1'b0, w_mant_trunc} + (MANT_W+1)'(w_round_up);

    // A carry out is only reachable from the unshifted case (0xFFFFFF + 1) and lands exactly on 2.0.
    always_comb begin
        if (w_rounded[MANT_W]) begin
            o_mant    = {1'b1, {(MANT_W-1){1'b0}}};
            o_exp_inc = 1'b1;
        end else begin
            o_mant    = w_rounded[MANT_W-1:0];
            o_exp_inc = w_top;
        end
    end
`else
    logic w_unused_low;

    assign w_unused_low = ^i_prod[22:0];
    assign o_mant       = w_mant_trunc;
    assign o_exp_inc    = w_top;
`endif

endmodule

// File: rtl/seq_mul24_frac.sv
// Radix-2 shift-add Q1.23 x Q1.23 mantissa multiplier: 24 MUL cycles, one NORM cycle, valid/ready result.
// Build option: MUL24_ROUND_EN selects round-to-nearest-even in the normalizer (latency unchanged).
module seq_mul24_frac
    import mul24_pkg::*;
(
    input  logic             clk,
    input  logic             arst_n,
    seq_mul24_frac_if.slave  bus
);

    state_t                r_state;
    state_t                w_state_next;
    logic [MANT_W-1:0]     r_a;
    logic [MANT_W-1:0]     r_hi;
    logic [MANT_W-1:0]     r_lo;
    logic [STEP_CNT_W-1:0] r_cnt;
    logic [MANT_W-1:0]     r_mant;
    logic                  r_exp_inc;
    logic                  r_out_valid;

    logic                  w_accept;
    logic                  w_last_step;
    logic [MANT_W:0]       w_sum;
    logic [MANT_W-1:0]     w_norm_mant;
    logic                  w_norm_exp_inc;

    assign w_accept    = bus.in_valid && (r_state == IDLE);
    assign w_last_step = (r_cnt == LAST_STEP);

    // 25-bit partial sum keeps the carry, which shifts into hi[23] on the same step.
    assign w_sum = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_a} : '0);

    mul24_norm_round u_norm_round (
        .i_prod    ({r_hi, r_lo}),
        .o_mant    (w_norm_mant),
        .o_exp_inc (w_norm_exp_inc)
    );

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // NOTE: the default assignment first keeps this block free of inferred latches.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (w_accept)      w_state_next = MUL;
            MUL:     if (w_last_step)   w_state_next = NORM;
            NORM:                       w_state_next = DONE;
            DONE:    if (bus.out_ready) w_state_next = IDLE;
            default:                    w_state_next = IDLE;
        endcase
    end

    // NOTE: the accumulator and counter are plain registers, so reset clears them outright.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_a         <= '0;
            r_hi        <= '0;
            r_lo        <= '0;
            r_cnt       <= '0;
            r_mant      <= '0;
            r_exp_inc   <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_a   <= bus.a;
                        r_hi  <= '0;
                        r_lo  <= bus.b;
                        r_cnt <= '0;
                    end
                end
                MUL: begin
                    {r_hi, r_lo} <= {w_sum, r_lo[MANT_W-1:1]};
                    r_cnt        <= r_cnt + STEP_CNT_W'(1);
                end
                NORM: begin
                    r_mant      <= w_norm_mant;
                    r_exp_inc   <= w_norm_exp_inc;
                    r_out_valid <= 1'b1;
                end
                DONE: begin
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = (r_state == IDLE);
    assign bus.out_valid = r_out_valid;
    assign bus.mant      = r_mant;
    assign bus.exp_inc   = r_exp_inc;

endmodule
